// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word fetches over a
// req/gnt/rvalid memory port, buffers returned words with their PCs and
// hands them to decode.
//
// Handshakes: the memory side accepts a request in any cycle where
// imem_req_o && imem_gnt_i, and returns exactly one in-order imem_rvalid_i
// per accepted request at least one cycle later. The decode side takes
// the FIFO head in any cycle where inst_valid_o && inst_ready_i. Once
// raised, inst_valid_o and inst_o/inst_pc_o stay put until that transfer
// or a redirect. imem_req_o and imem_addr_o stay put until a grant, except
// that a redirect cycle drops the request.
module instr_fetch #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] out_q, out_d;            // requests granted, response not yet seen
    logic [CNT_W-1:0] drop_q, drop_d;          // in-flight responses orphaned by a redirect
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [PTR_W-1:0] pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;

    logic [XLEN-1:0]  fifo_inst_q [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_pc_q   [FIFO_DEPTH];
    logic [XLEN-1:0]  pend_pc_q   [FIFO_DEPTH];

    logic             pop, fire, rsp, rsp_keep;
    logic [CNT_W-1:0] fifo_after_pop;
    logic [CNT_W:0]   in_use;

    // Low two redirect bits are forced to zero and never looked at.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Handshake decode and fetch credit. An entry being popped this cycle
    // counts as free: its slot is gone before any new response can land,
    // which is what lets a 1-cycle memory sustain one fetch per cycle.
    always_comb begin
        pop            = (fifo_cnt_q != '0) && inst_ready_i && !redirect_i;
        fifo_after_pop = pop ? (fifo_cnt_q - CNT_ONE) : fifo_cnt_q;
        in_use         = {1'b0, fifo_after_pop} + {1'b0, out_q};
        imem_req_o     = rst_n_i && !redirect_i && (in_use < DEPTH_C);
        fire           = imem_req_o && imem_gnt_i;
        rsp            = imem_rvalid_i && (out_q != '0);
        rsp_keep       = rsp && (drop_q == '0) && !redirect_i;
    end

    // Next-state for PC, counters and queue pointers; redirect overrides last.
    always_comb begin
        pc_d       = pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        fifo_cnt_d = fifo_cnt_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        pend_wr_d  = pend_wr_q;
        pend_rd_d  = pend_rd_q;

        if (fire) begin
            pc_d      = pc_q + XLEN'(4);
            pend_wr_d = pend_wr_q + PTR_ONE;
        end

        if (fire && !rsp) begin
            out_d = out_q + CNT_ONE;
        end else if (!fire && rsp) begin
            out_d = out_q - CNT_ONE;
        end

        if (rsp && (drop_q != '0)) begin
            drop_d = drop_q - CNT_ONE;
        end

        if (rsp_keep) begin
            pend_rd_d = pend_rd_q + PTR_ONE;
            fifo_wr_d = fifo_wr_q + PTR_ONE;
        end
        if (pop) begin
            fifo_rd_d = fifo_rd_q + PTR_ONE;
        end

        case ({rsp_keep, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        // Everything still in flight after this cycle's response belongs
        // to the old path and must be swallowed.
        if (redirect_i) begin
            pc_d       = {redirect_pc_i[XLEN-1:2], 2'b00};
            fifo_cnt_d = '0;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            pend_wr_d  = '0;
            pend_rd_d  = '0;
            drop_d     = out_d;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q       <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            fifo_cnt_q <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            pend_wr_q  <= '0;
            pend_rd_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            fifo_cnt_q <= fifo_cnt_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            pend_wr_q  <= pend_wr_d;
            pend_rd_q  <= pend_rd_d;
        end
    end

    // Data storage: pending PCs on grant, {pc, inst} on a kept response.
    always_ff @(posedge clk_i) begin
        if (fire) begin
            pend_pc_q[pend_wr_q] <= pc_q;
        end
        if (rsp_keep) begin
            fifo_inst_q[fifo_wr_q] <= imem_rdata_i;
            fifo_pc_q[fifo_wr_q]   <= pend_pc_q[pend_rd_q];
        end
    end

    // Outputs are zero whenever the buffer is empty, including in reset.
    assign imem_addr_o  = pc_q;
    assign inst_valid_o = (fifo_cnt_q != '0);
    assign inst_o       = inst_valid_o ? fifo_inst_q[fifo_rd_q] : '0;
    assign inst_pc_o    = inst_valid_o ? fifo_pc_q[fifo_rd_q]   : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a latency-configurable in-order memory
// model, per-cycle checks of request/address/valid and a scoreboard of
// the PCs expected at the decode side.
module tb_instr_fetch;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    instr_fetch dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc_n = 0;
    int          mem_lat = 1;
    logic        gnt_en = 1'b1;
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    logic [31:0] exp_q[$];

    logic        cur_req, cur_valid;
    logic [31:0] cur_addr, cur_pc, cur_inst;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0013_5A00;
    endfunction

    // One clock cycle: memory drives, outputs sampled 1 time unit later,
    // grants recorded, decode pops scored; returns at the next negedge.
    task automatic cyc();
        logic [31:0] a;
        logic [31:0] e;
        imem_gnt_i = gnt_en;
        if (mem_addr_q.size() != 0 && mem_due_q[0] <= cyc_n) begin
            a = mem_addr_q.pop_front();
            void'(mem_due_q.pop_front());
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = inst_of(a);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
        #1;
        cur_req   = imem_req_o;
        cur_addr  = imem_addr_o;
        cur_valid = inst_valid_o;
        cur_pc    = inst_pc_o;
        cur_inst  = inst_o;
        if (cur_req && imem_gnt_i) begin
            mem_addr_q.push_back(cur_addr);
            mem_due_q.push_back(cyc_n + mem_lat);
        end
        if (cur_valid && inst_ready_i && !redirect_i) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_pop", cur_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", cur_pc, e);
                chk("sb_inst", cur_inst, inst_of(e));
            end
        end
        @(negedge clk_i);
        cyc_n++;
    endtask

    // Reset block: asserts reset (memory model too), checks reset outputs.
    task automatic do_reset();
        rst_n_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        inst_ready_i  = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        gnt_en        = 1'b1;
        mem_lat       = 1;
        mem_addr_q.delete();
        mem_due_q.delete();
        exp_q.delete();
        #1;
        chk("rst_req",   32'(imem_req_o),   32'h0);
        chk("rst_addr",  imem_addr_o,       32'h0);
        chk("rst_valid", 32'(inst_valid_o), 32'h0);
        chk("rst_inst",  inst_o,            32'h0);
        chk("rst_pc",    inst_pc_o,         32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        cyc_n   = 0;
    endtask

    task automatic sb_drained(input string tag);
        chk(tag, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        // Streaming with 1-cycle memory and ready high.
        do_reset();
        inst_ready_i = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t1_req",   32'(cur_req),   32'h1);
            chk("t1_addr",  cur_addr,       32'(4 * i));
            chk("t1_valid", 32'(cur_valid), (i >= 2) ? 32'h1 : 32'h0);
        end
        sb_drained("t1_drain");

        // Backpressure: decode stalls for 10 cycles.
        do_reset();
        for (int i = 0; i < 10; i++) cyc();
        chk("t2_req_low",   32'(cur_req),   32'h0);
        chk("t2_valid",     32'(cur_valid), 32'h1);
        chk("t2_head_pc",   cur_pc,         32'h0);
        chk("t2_addr",      cur_addr,       32'h8);
        chk("t2_no_outst",  32'(mem_addr_q.size()), 32'h0);
        inst_ready_i = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h8};
        cyc();
        chk("t2_resume_req",  32'(cur_req), 32'h1);
        chk("t2_resume_addr", cur_addr,     32'h8);
        cyc();
        cyc();
        sb_drained("t2_drain");

        // Grant withheld for 3 cycles on 0x4.
        do_reset();
        inst_ready_i = 1'b1;
        exp_q = '{32'h0, 32'h4};
        cyc();
        gnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t3_hold_req",  32'(cur_req), 32'h1);
            chk("t3_hold_addr", cur_addr,     32'h4);
        end
        gnt_en = 1'b1;
        cyc();
        chk("t3_gnt_addr", cur_addr, 32'h4);
        cyc();
        chk("t3_next_addr", cur_addr, 32'h8);
        cyc();
        sb_drained("t3_drain");

        // Redirect to 0x103 with two fetches in flight (3-cycle memory).
        do_reset();
        inst_ready_i = 1'b1;
        mem_lat = 3;
        exp_q = '{32'h100};
        cyc();
        cyc();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        cyc();
        chk("t4_redir_req", 32'(cur_req), 32'h0);
        redirect_i = 1'b0;
        cyc();
        chk("t4_c3_addr",  cur_addr,       32'h100);
        chk("t4_c3_req",   32'(cur_req),   32'h0);
        chk("t4_c3_valid", 32'(cur_valid), 32'h0);
        cyc();
        chk("t4_c4_req",  32'(cur_req), 32'h1);
        chk("t4_c4_addr", cur_addr,     32'h100);
        cyc();
        chk("t4_c5_valid", 32'(cur_valid), 32'h0);
        chk("t4_c5_addr",  cur_addr,       32'h104);
        cyc();
        cyc();
        chk("t4_c7_valid", 32'(cur_valid), 32'h0);
        cyc();
        chk("t4_c8_valid", 32'(cur_valid), 32'h1);
        sb_drained("t4_drain");

        // Redirect coinciding with rvalid and a pop.
        do_reset();
        inst_ready_i = 1'b1;
        exp_q = '{32'h40};
        cyc();
        cyc();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0040;
        cyc();
        chk("t5_r_valid", 32'(cur_valid), 32'h1);
        chk("t5_r_req",   32'(cur_req),   32'h0);
        redirect_i = 1'b0;
        cyc();
        chk("t5_c3_valid", 32'(cur_valid), 32'h0);
        chk("t5_c3_req",   32'(cur_req),   32'h1);
        chk("t5_c3_addr",  cur_addr,       32'h40);
        cyc();
        chk("t5_c4_valid", 32'(cur_valid), 32'h0);
        cyc();
        sb_drained("t5_drain");

        // PC wrap at the top of the address space (low bits ignored).
        do_reset();
        inst_ready_i  = 1'b1;
        exp_q = '{32'hFFFF_FFFC, 32'h0};
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        cyc();
        chk("t6_redir_req", 32'(cur_req), 32'h0);
        redirect_i = 1'b0;
        cyc();
        chk("t6_top_addr", cur_addr, 32'hFFFF_FFFC);
        cyc();
        chk("t6_wrap_addr", cur_addr, 32'h0);
        cyc();
        cyc();
        sb_drained("t6_drain");

        // Back-to-back redirects: latest wins, drop count recomputed.
        do_reset();
        inst_ready_i = 1'b1;
        mem_lat = 3;
        exp_q = '{32'h300};
        cyc();
        cyc();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        cyc();
        redirect_pc_i = 32'h0000_0300;
        cyc();
        redirect_i = 1'b0;
        cyc();
        chk("t7_c4_req",  32'(cur_req), 32'h1);
        chk("t7_c4_addr", cur_addr,     32'h300);
        cyc();
        chk("t7_c5_addr", cur_addr, 32'h304);
        cyc();
        cyc();
        chk("t7_c7_valid", 32'(cur_valid), 32'h0);
        cyc();
        sb_drained("t7_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction-fetch stage directly upstream of the decode/control path. Holds the PC and issues word fetches to instruction memory over a req/gnt/rvalid interface. Buffers returned instructions with their PCs in a small FIFO and presents them to decode with a valid/ready handshake. Accepts a redirect (branch/jump) that flushes buffered and in-flight fetches.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, PC fetched first after reset
FIFO_DEPTH, 2, instruction buffer entries; also the cap on outstanding fetches (power of 2, >=2)

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
imem_req_o  output  1  fetch request
imem_addr_o  output  XLEN  fetch address, word aligned
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response data valid; in-order, >=1 cycle after gnt
imem_rdata_i  input  XLEN  fetched instruction
redirect_i  input  1  flush and restart fetch
redirect_pc_i  input  XLEN  new PC; bits [1:0] ignored (treated as 0)
inst_valid_o  output  1  buffered instruction available to decode
inst_ready_i  input  1  decode accepts instruction
inst_o  output  XLEN  instruction (FIFO head)
inst_pc_o  output  XLEN  PC of inst_o

Behaviour:
- Reset (async, rst_n_i low): pc_q=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0, FIFO and pending-PC queue empty, outstanding=0, drop_cnt=0. Reset mid-transaction discards all state; responses arriving later are ignored only if drop logic still counts them, so memory must be reset together with this block.
- Credit: imem_req_o=1 when (fifo_count + outstanding) < FIFO_DEPTH and redirect_i=0. imem_addr_o=pc_q.
- Request held stable (same addr) until gnt, except a redirect cycle drops req for that cycle.
- On req&&gnt: push pc_q to pending-PC queue, pc_q+=4 (wraps modulo 2^XLEN), outstanding+=1.
- On rvalid: outstanding-=1. If drop_cnt>0: discard, drop_cnt-=1. Else pop pending-PC queue, push {pc, imem_rdata_i} into FIFO. rvalid with outstanding=0 is ignored.
- Output: inst_valid_o = FIFO non-empty (registered; response visible the cycle after rvalid, no bypass). Pop when inst_valid_o&&inst_ready_i. Simultaneous push and pop legal at any occupancy; credit rule guarantees no overflow.
- Minimum latency: req+gnt in cycle N, rvalid in N+1, inst_valid_o in N+2. Sustained throughput 1 instr/cycle with 1-cycle memory and ready held high.
- Redirect (redirect_i=1, cycle R): pc_q <= {redirect_pc_i[XLEN-1:2],2'b00}; FIFO and pending-PC queue cleared; inst_valid_o=0 from R+1; no request issued in R; drop_cnt <= outstanding after R's rvalid accounting (a response arriving in R is discarded, as are all still in flight). Pop in cycle R is ignored. First request for the new PC in R+1.
- Back-to-back redirects: latest wins; drop_cnt recomputed from outstanding each time.
- inst_ready_i low indefinitely: FIFO fills, req deasserts when credits exhausted; no data loss.

Test Plan:
- Reset release, 1-cycle memory, ready=1 -> addrs 0x0,0x4,0x8 on consecutive cycles; inst_pc_o 0x0 first valid 2 cycles after first gnt, then one per cycle.
- ready=0 for 10 cycles -> exactly 2 instrs buffered, req low, 0 outstanding; ready=1 -> PCs 0x0,0x4 delivered in order, fetching resumes at 0x8.
- gnt withheld 3 cycles on addr 0x4 -> imem_addr_o stays 0x4 with req high; no PC skipped.
- Redirect to 0x103 with 2 outstanding -> next req addr 0x100; both in-flight responses dropped; first inst_pc_o after redirect is 0x100.
- Redirect in same cycle as rvalid and pop -> that response dropped, pop ignored, inst_valid_o low next cycle.
- pc_q=0xFFFF_FFFC, gnt -> next addr 0x0000_0000 (wrap).
